// File: rtl/tt_strobe_pkg.sv
// Shared types and limits for the two-phase strobe sequencer.
package tt_strobe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PHASE_A,
        GAP1,
        PHASE_B,
        GAP2,
        DONE
    } state_t;

    localparam int CNT_W_DEF   = 8;
    localparam int PULSE_W_MIN = 1;
    localparam int GAP_W_MIN   = 1;

endpackage

// File: rtl/tt_strobe_sequencer_if.sv
// Request/strobe/response bundle between requester, sequencer and responder.
// TT_STROBE_REPEAT_EN adds the burst_len request field.
interface tt_strobe_sequencer_if;
    logic       start;
    logic       sel_in;
    logic       resp_in;
    logic       sel_out;
    logic       phase_a;
    logic       phase_b;
    logic       busy;
    logic       done;
    logic       resp_a;
    logic       resp_b;
`ifdef TT_STROBE_REPEAT_EN
    logic [3:0] burst_len;
`endif

    modport master (
        input  start, sel_in, resp_in,
`ifdef TT_STROBE_REPEAT_EN
        input  burst_len,
`endif
        output sel_out, phase_a, phase_b, busy, done, resp_a, resp_b
    );

    modport slave (
        output start, sel_in, resp_in,
`ifdef TT_STROBE_REPEAT_EN
        output burst_len,
`endif
        input  sel_out, phase_a, phase_b, busy, done, resp_a, resp_b
    );
endinterface

// File: rtl/tt_strobe_timer.sv
// Loadable down-counter with terminal-count flag; holds when en is low.
module tt_strobe_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            if (load)
                cnt <= load_val;
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/tt_strobe_sequencer.sv
// Two-phase strobe sequencer: latched select, non-overlapping phase_a/phase_b,
// response sampling and done pulse. TT_STROBE_REPEAT_EN enables burst repeats.
//
// state   | meaning
// IDLE    | waiting for start
// SETUP   | select settles before strobe A (GAP_W cycles)
// PHASE_A | phase_a high (PULSE_W cycles)
// GAP1    | non-overlap gap (GAP_W cycles)
// PHASE_B | phase_b high (PULSE_W cycles)
// GAP2    | hold time after strobe B (GAP_W cycles)
// DONE    | one-cycle completion pulse
module tt_strobe_sequencer
    import tt_strobe_pkg::*;
#(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 2,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    tt_strobe_sequencer_if.master bus
);
    if (PULSE_W < PULSE_W_MIN || GAP_W < GAP_W_MIN ||
        PULSE_W > (2**CNT_W - 1) || GAP_W > (2**CNT_W - 1)) begin : g_bad_param
        $error("tt_strobe_sequencer: PULSE_W/GAP_W out of range");
    end

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);

    state_t           state;
    logic             zero;
    logic             load;
    logic [CNT_W-1:0] load_val;
`ifdef TT_STROBE_REPEAT_EN
    logic [3:0]       iter_left;
`endif

    // Reload value is the length of the state being entered, minus one.
    always_comb begin
        load     = 1'b0;
        load_val = '0;
        case (state)
            IDLE:    begin load = bus.start; load_val = GAP_LD;   end
            SETUP:   begin load = zero;      load_val = PULSE_LD; end
            PHASE_A: begin load = zero;      load_val = GAP_LD;   end
            GAP1:    begin load = zero;      load_val = PULSE_LD; end
            PHASE_B: begin load = zero;      load_val = GAP_LD;   end
            GAP2:    begin load = zero;      load_val = GAP_LD;   end
            default: begin load = 1'b0;      load_val = '0;       end
        endcase
    end

    tt_strobe_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (ena),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            bus.sel_out <= 1'b0;
            bus.phase_a <= 1'b0;
            bus.phase_b <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.resp_a  <= 1'b0;
            bus.resp_b  <= 1'b0;
`ifdef TT_STROBE_REPEAT_EN
            iter_left   <= '0;
`endif
        end else if (ena) begin
            case (state)
                IDLE: if (bus.start) begin
                    bus.sel_out <= bus.sel_in;
                    bus.busy    <= 1'b1;
                    state       <= SETUP;
`ifdef TT_STROBE_REPEAT_EN
                    iter_left   <= bus.burst_len;
`endif
                end
                SETUP: if (zero) begin
                    bus.phase_a <= 1'b1;
                    state       <= PHASE_A;
                end
                PHASE_A: if (zero) begin
                    bus.phase_a <= 1'b0;
                    bus.resp_a  <= bus.resp_in;
                    state       <= GAP1;
                end
                GAP1: if (zero) begin
                    bus.phase_b <= 1'b1;
                    state       <= PHASE_B;
                end
                PHASE_B: if (zero) begin
                    bus.phase_b <= 1'b0;
                    bus.resp_b  <= bus.resp_in;
                    state       <= GAP2;
                end
                GAP2: if (zero) begin
`ifdef TT_STROBE_REPEAT_EN
                    if (iter_left != '0) begin
                        iter_left   <= iter_left - 1'b1;
                        bus.sel_out <= ~bus.sel_out;
                        state       <= SETUP;
                    end else begin
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
`else
                    bus.done <= 1'b1;
                    state    <= DONE;
`endif
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/tt_strobe_sequencer.md
Name: tt_strobe_sequencer

Overview:
- Drive side of the two-phase strobe interface.
- Produces a latched select level (`sel_out`) and two non-overlapping strobe pulses, `phase_a` then `phase_b`.
- These feed a two-flop gated-capture responder on its select/clock-A/clock-B inputs.
- Samples the responder's combined return line during each phase and reports both samples with a done pulse.

Parameters:
- PULSE_W, 4: strobe high time in clk cycles (legal range 1..2^CNT_W-1).
- GAP_W, 2: setup/non-overlap gap in clk cycles (legal range 1..2^CNT_W-1). Guarantees `phase_a` and `phase_b` are never high together.
- CNT_W, 8: width of the internal down-counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- ena  input  1  global enable; low freezes the sequencer.
- start  input  1  request one sequence; sampled only in IDLE.
- sel_in  input  1  select value for the sequence; latched with start.
- resp_in  input  1  return line from responder (gated OR of its two captures).
- sel_out  output  1  latched select driven to responder.
- phase_a  output  1  strobe A.
- phase_b  output  1  strobe B.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle completion pulse.
- resp_a  output  1  resp_in sampled on last cycle of phase A.
- resp_b  output  1  resp_in sampled on last cycle of phase B.

Behaviour:
- Reset: rst_n low at a clk edge forces IDLE and clears all outputs (sel_out, phase_a, phase_b, busy, done, resp_a, resp_b = 0), including mid-sequence. No strobe is left high.
- Outputs are all registered (Moore style).
- States and transitions:
  - IDLE: start & ena at an edge latches sel_in into sel_out and loads counter = GAP_W-1; next state SETUP. busy goes high in the next cycle.
  - SETUP (GAP_W cycles, sel_out stable) -> PHASE_A.
  - PHASE_A (PULSE_W cycles, phase_a=1) -> GAP1.
  - GAP1 (GAP_W cycles) -> PHASE_B.
  - PHASE_B (PULSE_W cycles, phase_b=1) -> GAP2.
  - GAP2 (GAP_W cycles) -> DONE.
  - DONE (1 cycle, done=1, busy=1) -> IDLE.
- Each timed state leaves when the counter reaches 0 at an edge. The counter reloads for the next state in the same edge.
- resp_a and resp_b update only on the final cycle of PHASE_A and PHASE_B respectively, and hold until the next sequence's sample or reset.
- sel_out holds its value after DONE until the next start.
- start while busy is ignored and not queued.
- start in the DONE cycle is ignored.
- start and sel_in changing after latch have no effect.
- ena low: state, counter and all outputs hold; phase pulses stretch accordingly; done stays asserted if frozen in DONE. ena rising resumes exactly where frozen.
- Total busy length = 3*GAP_W + 2*PULSE_W + 1 cycles. Defaults give 15.

Optional Feature:
- Macro: TT_STROBE_REPEAT_EN.
- Enabled:
  - Adds input burst_len [3:0], latched with start.
  - The sequence runs burst_len+1 iterations back-to-back: after GAP2, non-final iterations go to SETUP, not DONE.
  - sel_out inverts at the start of each subsequent iteration.
  - resp_a and resp_b reflect the final iteration.
  - done pulses once, after the final iteration.
- Disabled: no burst_len port; exactly one iteration per start.

Decomposition:
- Package tt_strobe_pkg holds:
  - state enum (IDLE, SETUP, PHASE_A, GAP1, PHASE_B, GAP2, DONE);
  - CNT_W default;
  - localparams for minimum PULSE_W and GAP_W (1).
- Sub-module tt_strobe_timer: CNT_W down-counter with load, value, enable (ena) and zero flag. Instantiated once.
- FSM and output registers live in the top.

Test Plan:
- Reset and basic run: reset, then start=1, sel_in=1 at cycle 0 with defaults.
  - sel_out=1 from cycle 1, phase_a=1 cycles 3-6, phase_b=1 cycles 9-12, done=1 cycle 15, busy=1 cycles 1-15.
  - phase_a & phase_b never both 1.
- Response capture: responder model with sel=1 returns 1 only during phase A.
  - Expect resp_a=1, resp_b=0.
  - Repeat with sel_in=0: expect resp_a=0, resp_b=1.
- Start while busy: pulse start at cycles 5 and 15.
  - Exactly one done (cycle 15); no second sequence starts.
  - busy=0 at cycle 16.
- ena freeze: drop ena for cycles 4-7 during PHASE_A.
  - phase_a stays high 8 cycles total; done moves to cycle 19.
- Reset mid-operation: rst_n=0 at cycle 10 (phase_b high).
  - All outputs 0 at cycle 11.
  - A new start after release yields a full 15-cycle sequence.
- TT_STROBE_REPEAT_EN defined, burst_len=2, sel_in=1:
  - three A/B pulse pairs; sel_out 1, 0, 1 per iteration;
  - single done at cycle 3*14+1 = 43.
